// File: rtl/audio_dac_writer.sv
// Codec transmit path: buffers mono samples in a small FIFO and issues one
// codec write per sample, left-justified to 24 bits on both channels.
module audio_dac_writer #(
  parameter int DEPTH        = 8,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] inSample,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic                    mute,
  input  logic                    writeReady,
  output logic                    write,
  output logic [23:0]             writeDataLeft,
  output logic [23:0]             writeDataRight,
  output logic [7:0]              dropCount,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  fillLevel
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ARM, ISSUE, COOLDOWN} state_t;

  state_t                  state_q, state_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
  logic                    write_q, write_d;
  logic [23:0]             data_q, data_d;
  logic [7:0]              drop_q, drop_d;
  logic                    underrun_q, underrun_d;
  logic                    issued_q, issued_d;
  logic                    empty, full, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = inValid && !full;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    write_d    = 1'b0;
    data_d     = data_q;
    drop_d     = drop_q;
    underrun_d = underrun_q;
    issued_d   = issued_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (inValid && full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (!empty) state_d = ARM;
        else if (writeReady && issued_q) underrun_d = 1'b1;
      end
      // Data and strobe are registered on entry to ISSUE so they appear together.
      ARM: begin
        if (writeReady) begin
          state_d = ISSUE;
          write_d = 1'b1;
          data_d  = mute ? '0 : (24'(mem_q[rd_ptr_q[AW-1:0]]) << (24 - SAMPLE_WIDTH));
        end
      end
      ISSUE: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        issued_d = 1'b1;
        state_d  = COOLDOWN;
      end
      COOLDOWN: state_d = empty ? IDLE : ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      write_q    <= 1'b0;
      data_q     <= '0;
      drop_q     <= '0;
      underrun_q <= 1'b0;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      write_q    <= write_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      underrun_q <= underrun_d;
      issued_q   <= issued_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= inSample;
  end

  assign inReady        = !full;
  assign write          = write_q;
  assign writeDataLeft  = data_q;
  assign writeDataRight = data_q;
  assign dropCount      = drop_q;
  assign underrun       = underrun_q;
  assign fillLevel      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_audio_dac_writer.sv
// Scoreboard bench for audio_dac_writer: occupancy-based reference model feeds
// an expected-word queue that a negedge monitor drains on every write pulse.
module tb_audio_dac_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inSample = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        mute = 1'b0;
  logic        writeReady = 1'b0;
  logic        write;
  logic [23:0] writeDataLeft, writeDataRight;
  logic [7:0]  dropCount;
  logic        underrun;
  logic [3:0]  fillLevel;

  audio_dac_writer #(.DEPTH(DEPTH), .SAMPLE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .inSample(inSample), .inValid(inValid),
    .inReady(inReady), .mute(mute), .writeReady(writeReady), .write(write),
    .writeDataLeft(writeDataLeft), .writeDataRight(writeDataRight),
    .dropCount(dropCount), .underrun(underrun), .fillLevel(fillLevel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  int wr_cycles[$];
  int n_acc = 0;
  int n_wr = 0;
  int drop_m = 0;
  int last_wcyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse is checked against the head of the scoreboard.
  bit          prev_w = 1'b0;
  bit          prev_rdy = 1'b0;
  logic [23:0] last_word = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_w = 1'b0; prev_rdy = 1'b0; last_word = '0;
      end else begin
        if (write) begin
          n_wr++;
          last_wcyc = cyc;
          wr_cycles.push_back(cyc);
          chk("no_back_to_back", {31'b0, prev_w}, 32'd0);
          chk("ready_seen_in_arm", {31'b0, prev_rdy}, 32'd1);
          chk("right_eq_left", {8'b0, writeDataRight}, {8'b0, writeDataLeft});
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            chk("write_data", {8'b0, writeDataLeft}, {8'b0, exp_q.pop_front()});
          end
          last_word = writeDataLeft;
        end else begin
          chk("data_hold", {8'b0, writeDataLeft}, {8'b0, last_word});
        end
        prev_w = write;
        prev_rdy = writeReady;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [15:0] s);
    if (n_acc - n_wr == DEPTH) begin
      if (drop_m < 255) drop_m++;
    end else begin
      exp_q.push_back(mute ? 24'h0 : {s, 8'h00});
      n_acc++;
    end
    inValid = 1'b1; inSample = s;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin idle(1); k++; end
    chk("drain_complete", exp_q.size(), 32'd0);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_fill", {28'b0, fillLevel}, 32'd0);
    chk("rst_inready", {31'b0, inReady}, 32'd1);
    chk("rst_left", {8'b0, writeDataLeft}, 32'd0);
    chk("rst_right", {8'b0, writeDataRight}, 32'd0);
    chk("rst_drop", {24'b0, dropCount}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    n_acc = n_wr;
    drop_m = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int cs;
    int n0;
    idle(3);
    do_reset();

    writeReady = 1'b1;
    idle(4);
    chk("no_underrun_before_first", {31'b0, underrun}, 32'd0);

    // Single sample: latency 3, then underrun once idle with codec ready.
    cs = cyc;
    strobe(16'h8001);
    idle(6);
    chk("latency", last_wcyc, cs + 3);
    chk("single_underrun", {31'b0, underrun}, 32'd1);
    chk("single_fill", {28'b0, fillLevel}, 32'd0);

    // Muted samples are consumed but carry zero data.
    mute = 1'b1;
    strobe(16'h1234);
    idle(1);
    strobe(16'h7FFF);
    drain(40);
    mute = 1'b0;
    chk("mute_fill", {28'b0, fillLevel}, 32'd0);
    chk("mute_drop", {24'b0, dropCount}, drop_m);

    // Burst of 10 into a stalled codec.
    writeReady = 1'b0;
    idle(2);
    for (int i = 0; i < 10; i++) strobe(16'($urandom));
    chk("burst_fill", {28'b0, fillLevel}, 32'd8);
    chk("burst_inready", {31'b0, inReady}, 32'd0);
    chk("burst_drop", {24'b0, dropCount}, drop_m);
    chk("burst_drop_const", {24'b0, dropCount}, 32'd2);
    wr_cycles.delete();
    writeReady = 1'b1;
    drain(80);
    chk("burst_writes", wr_cycles.size(), 32'd8);
    for (int i = 1; i < wr_cycles.size(); i++)
      chk("burst_spacing", wr_cycles[i] - wr_cycles[i-1], 32'd3);

    // writeReady toggled every 5 cycles with 4 buffered samples.
    writeReady = 1'b0;
    for (int i = 0; i < 4; i++) strobe(16'($urandom));
    n0 = n_wr;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      writeReady = ((k / 5) % 2) == 0;
      idle(1);
    end
    writeReady = 1'b1;
    drain(40);
    chk("toggle_count", n_wr - n0, 32'd4);

    // Random traffic with random codec back-pressure.
    for (int k = 0; k < 300; k++) begin
      writeReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) strobe(16'($urandom));
      else idle(1);
      if (k % 50 == 0) chk("rand_fill", {28'b0, fillLevel}, n_acc - n_wr);
    end
    writeReady = 1'b1;
    drain(100);
    chk("rand_drop", {24'b0, dropCount}, drop_m);

    // Saturating drop counter.
    writeReady = 1'b0;
    for (int i = 0; i < DEPTH + 300; i++) strobe(16'($urandom));
    chk("sat_drop", {24'b0, dropCount}, 32'd255);
    chk("sat_drop_model", {24'b0, dropCount}, drop_m);
    chk("sat_inready", {31'b0, inReady}, 32'd0);

    // Clear, queue 5, then reset while in ISSUE.
    do_reset();
    for (int i = 0; i < 5; i++) strobe(16'($urandom));
    idle(2);
    chk("pre_issue_fill", {28'b0, fillLevel}, 32'd5);
    writeReady = 1'b1;
    idle(1);
    chk("in_issue_write", {31'b0, write}, 32'd1);
    do_reset();
    idle(10);
    chk("post_rst_underrun", {31'b0, underrun}, 32'd0);
    chk("post_rst_fill", {28'b0, fillLevel}, 32'd0);
    n0 = n_wr;
    strobe(16'hC3A5);
    drain(20);
    chk("post_rst_delivery", n_wr - n0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
